// File: rtl/ibis_tmds_pkg.sv
// Shared TMDS pump-sequencer constants: control tokens, state encoding
// and the serializer phase count.
package ibis_tmds_pkg;

    localparam logic [9:0] CTRL_TOKEN   = 10'b1101010100;
    localparam logic [9:0] CTRL_TOKEN_1 = 10'b0010101011;
    localparam logic [9:0] CTRL_TOKEN_2 = 10'b0101010100;
    localparam logic [9:0] CTRL_TOKEN_3 = 10'b1010101011;

    localparam int PUMP_PHASES = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRAIN = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } tmds_seq_state_t;

endpackage

// File: rtl/ibis_tmds_word_fifo.sv
// Synchronous word FIFO with valid/ready push and pop strobe.
// Pointers carry one extra MSB to separate full from empty.
module ibis_tmds_word_fifo
    import ibis_tmds_pkg::*;
#(
    parameter int WIDTH = 30,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push_valid,
    output logic             o_push_ready,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_push;
    logic             w_pop;

    assign o_empty      = (r_wr_ptr == r_rd_ptr);
    assign o_full       = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                          (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_push_ready = !o_full;
    assign w_push       = i_push_valid && o_push_ready;
    assign w_pop        = i_pop && !o_empty;
    assign o_pop_data   = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/ibis_tmds_pump_sequencer.sv
// Shared enable, 5-phase load cadence and word feed for lockstep TMDS pumps.
// Define IBIS_TMDS_SEQ_STATS_EN to add the saturating o_underrun_count port.
module ibis_tmds_pump_sequencer
    import ibis_tmds_pkg::*;
#(
    parameter int CHANNELS    = 3,
    parameter int TRAIN_WORDS = 1024,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   i_start,
    input  logic                   i_stop,
    input  logic [CHANNELS*10-1:0] s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic                   o_pump_enable,
    output logic [CHANNELS*10-1:0] o_pump_words,
    output logic                   o_load,
    output logic [1:0]             o_state,
    output logic                   o_underrun,
    input  logic                   i_clear_underrun
`ifdef IBIS_TMDS_SEQ_STATS_EN
   ,output logic [15:0]            o_underrun_count
`endif
);

    localparam int         W          = CHANNELS * 10;
    localparam logic [W-1:0] CTRL_WORD = {CHANNELS{CTRL_TOKEN}};
    localparam logic [15:0] TRAIN_LAST = 16'(TRAIN_WORDS - 1);
    localparam logic [2:0]  PH_LAST    = 3'(PUMP_PHASES - 1);

    tmds_seq_state_t r_state, w_state_nx;
    logic            r_enable, w_enable_nx;
    logic [2:0]      r_phase;
    logic [W-1:0]    r_words, w_words_nx;
    logic [15:0]     r_train_cnt, w_train_nx;
    logic            r_underrun;
    logic            w_underrun_set;
    logic            w_ph4;
    logic            w_accept;
    logic            w_fifo_ready;
    logic            w_fifo_empty;
    logic            w_fifo_full;
    logic            w_pop;
    logic [W-1:0]    w_fifo_data;

    assign w_ph4    = r_enable && (r_phase == PH_LAST);
    assign w_accept = (r_state == TRAIN) || (r_state == RUN);
    assign s_ready  = w_accept && w_fifo_ready;

    assign o_pump_enable = r_enable;
    assign o_pump_words  = r_words;
    assign o_load        = r_enable && (r_phase == 3'd0);
    assign o_state       = r_state;
    assign o_underrun    = r_underrun;

    ibis_tmds_word_fifo #(
        .WIDTH (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (aclk),
        .rst          (areset),
        .i_push_valid (s_valid && w_accept),
        .o_push_ready (w_fifo_ready),
        .i_push_data  (s_data),
        .i_pop        (w_pop),
        .o_pop_data   (w_fifo_data),
        .o_empty      (w_fifo_empty),
        .o_full       (w_fifo_full)
    );

    always_comb begin
        w_state_nx     = r_state;
        w_enable_nx    = r_enable;
        w_words_nx     = r_words;
        w_train_nx     = r_train_cnt;
        w_pop          = 1'b0;
        w_underrun_set = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_start && !i_stop) begin
                    w_state_nx  = TRAIN;
                    w_enable_nx = 1'b1;
                    w_words_nx  = CTRL_WORD;
                    w_train_nx  = '0;
                end
            end
            TRAIN: begin
                if (w_ph4) begin
                    if (r_train_cnt == TRAIN_LAST) begin
                        // first data word goes out on the edge that leaves TRAIN
                        w_state_nx = RUN;
                        if (!w_fifo_empty) begin
                            w_pop      = 1'b1;
                            w_words_nx = w_fifo_data;
                        end else begin
                            w_words_nx = CTRL_WORD;
                        end
                    end else begin
                        w_train_nx = r_train_cnt + 16'd1;
                        w_words_nx = CTRL_WORD;
                    end
                end
                if (i_stop) w_state_nx = DRAIN;
            end
            RUN: begin
                if (w_ph4) begin
                    if (!w_fifo_empty) begin
                        w_pop      = 1'b1;
                        w_words_nx = w_fifo_data;
                    end else begin
                        w_words_nx     = CTRL_WORD;
                        w_underrun_set = 1'b1;
                    end
                end
                if (i_stop) w_state_nx = DRAIN;
            end
            DRAIN: begin
                if (w_ph4) begin
                    if (!w_fifo_empty) begin
                        w_pop      = 1'b1;
                        w_words_nx = w_fifo_data;
                    end else begin
                        w_words_nx  = CTRL_WORD;
                        w_state_nx  = IDLE;
                        w_enable_nx = 1'b0;
                    end
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state     <= IDLE;
            r_enable    <= 1'b0;
            r_phase     <= '0;
            r_words     <= CTRL_WORD;
            r_train_cnt <= '0;
            r_underrun  <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_enable    <= w_enable_nx;
            r_words     <= w_words_nx;
            r_train_cnt <= w_train_nx;
            if (!r_enable || r_phase == PH_LAST) r_phase <= '0;
            else                                 r_phase <= r_phase + 3'd1;
            if (w_underrun_set)        r_underrun <= 1'b1;
            else if (i_clear_underrun) r_underrun <= 1'b0;
        end
    end

`ifdef IBIS_TMDS_SEQ_STATS_EN
    logic [15:0] r_ucount;

    assign o_underrun_count = r_ucount;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_ucount <= '0;
        end else if (w_underrun_set) begin
            if (i_clear_underrun)       r_ucount <= 16'd1;
            else if (r_ucount != '1)    r_ucount <= r_ucount + 16'd1;
        end else if (i_clear_underrun) begin
            r_ucount <= '0;
        end
    end
`endif

endmodule
